cache_port_arbiter: RTL and testbench
=====================================

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, request address width.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter RD_LAT, 2, cache read latency in cycles (registered-input SRAM).
REQ-004 SHALL have parameter OFFSET_W, 4, line offset bits; INDEX_W, 8, line index bits (256 lines).
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports if_req_valid in 1, if_req_addr in ADDR_W: instruction-fetch read request.
REQ-008 SHALL have port if_req_ready  out  1  IF request accepted this cycle.
REQ-009 SHALL have ports if_rsp_valid out 1, if_rsp_data out DATA_W: IF read response.
REQ-010 SHALL have ports dm_req_valid in 1, dm_req_we in 1, dm_req_addr in ADDR_W, dm_req_wdata in DATA_W: data-memory request.
REQ-011 SHALL have port dm_req_ready  out  1  DM request accepted this cycle.
REQ-012 SHALL have ports dm_rsp_valid out 1, dm_rsp_data out DATA_W: DM read response.
REQ-013 SHALL have ports c_raddr_valid out 1, c_raddr out ADDR_W: cache read port.
REQ-014 SHALL have ports c_waddr_valid out 1, c_waddr out ADDR_W, c_wdata out DATA_W: cache write port.
REQ-015 SHALL have ports c_rdata in DATA_W (read data, RD_LAT after issue), c_stall in 1 (cache busy, no new issue).

Function
REQ-016 SHALL grant at most one request per cycle; transfer occurs when req_valid and req_ready both high in the same cycle.
REQ-017 SHALL drive req_ready combinationally, never high for a requester whose valid is low.
REQ-018 SHALL arbitrate round-robin: when both valid, grant the requester not granted last; single valid requester granted directly.
REQ-019 SHALL update last-grant register only on an actual grant.
REQ-020 SHALL on a granted read drive c_raddr_valid=1 and c_raddr=request address in the grant cycle (combinational pass-through).
REQ-021 SHALL on a granted DM write drive c_waddr_valid=1, c_waddr, c_wdata in the grant cycle; writes produce no response.
REQ-022 SHALL hold c_raddr_valid and c_waddr_valid low in any cycle with no grant; never both high in one cycle.
REQ-023 SHALL deassert both readies while c_stall=1; in-flight responses continue to drain during stall.
REQ-024 SHALL track in-flight reads in an RD_LAT-deep shift register of {valid, requester id}, advancing every cycle.
REQ-025 SHALL assert exactly one of if_rsp_valid/dm_rsp_valid for one cycle, exactly RD_LAT cycles after grant, with rsp_data=c_rdata.
REQ-026 SHALL drive rsp_data to zero when the corresponding rsp_valid is low.
REQ-027 SHALL block (ready low) any read whose index addr[OFFSET_W +: INDEX_W] equals the index of a write granted in the previous cycle (RAW guard); the other requester may be granted instead.
REQ-028 SHALL not count a RAW-blocked cycle as a grant for round-robin purposes.
REQ-029 SHALL accept back-to-back reads every cycle, sustaining one response per cycle.

Reset
REQ-030 SHALL on rst low immediately clear all readies, rsp_valids, cache valids, in-flight pipeline and last-write register.
REQ-031 SHALL reset last-grant to DM so IF wins the first tie.
REQ-032 SHALL drop reads in flight at reset assertion; no response emitted for them after release.

Structure
REQ-033 SHALL place requester-id enum (REQ_IF, REQ_DM) and in-flight entry struct in shared package cache_pkg.
REQ-034 SHALL place RD_LAT, OFFSET_W, INDEX_W defaults in cache_pkg as localparams.
REQ-035 SHALL implement the in-flight tracker as sub-module rsp_tag_pipe (parameter RD_LAT).

Verification
REQ-036 SHALL cover: IF read addr 0x100 alone at cycle 0 -> if_req_ready=1 cycle 0, c_raddr=0x100, if_rsp_valid cycle 2 with c_rdata value.
REQ-037 SHALL cover: IF and DM reads valid continuously from reset -> grants IF,DM,IF,DM; responses route to matching requester at +2.
REQ-038 SHALL cover: DM write 0x2040 cycle 0, IF read 0x2048 cycle 1 (same index) -> if_req_ready=0 cycle 1, granted cycle 2.
REQ-039 SHALL cover: c_stall=1 cycles 3-5 with reads pending -> no readies cycles 3-5, reads granted cycles 1-2 still respond cycles 3-4.
REQ-040 SHALL cover: rst low one cycle after read grant -> no rsp_valid afterwards, all outputs zero during reset.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache port arbiter.
//   req_id_e   : which requester owns a transaction (instruction fetch or data memory)
//   inflight_t : one slot of the read-response tracker {valid, requester id}
//   other_req  : helper returning the opposite requester, used by round-robin
package cache_pkg;

    localparam int CACHE_RD_LAT   = 2;
    localparam int CACHE_OFFSET_W = 4;
    localparam int CACHE_INDEX_W  = 8;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } inflight_t;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_IF) ? REQ_DM : REQ_IF;
    endfunction

endpackage

// File: rtl/rsp_tag_pipe.sv
// In-flight read tracker: an RD_LAT-deep shift register of {valid, requester id}.
// A tag entering on entry_i emerges on entry_o exactly RD_LAT cycles later,
// lined up with the cache read data for that request.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, drops every tracked read
//   entry_i  : tag of the read issued this cycle (valid=0 when none)
//   entry_o  : tag whose data is on the cache read bus this cycle
module rsp_tag_pipe
    import cache_pkg::*;
#(
    parameter int RD_LAT = CACHE_RD_LAT
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  inflight_t entry_i,
    output inflight_t entry_o
);

    inflight_t stage_q [RD_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '{valid: 1'b0, id: REQ_IF};
            end
        end else begin
            stage_q[0] <= entry_i;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign entry_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/cache_port_arbiter.sv
// Two-requester arbiter in front of a single-ported cache.
// Grants at most one of instruction fetch (IF, read only) or data memory
// (DM, read or write) per cycle, round-robin on contention, passes the
// granted request straight to the cache read or write port, and routes read
// data back to the owner RD_LAT cycles later.
//   clk, rst                        : clock, asynchronous active-low reset
//   if_req_valid/addr, if_req_ready : IF read request handshake
//   if_rsp_valid/data               : IF read response
//   dm_req_valid/we/addr/wdata, dm_req_ready : DM request handshake
//   dm_rsp_valid/data               : DM read response
//   c_raddr_valid/c_raddr           : cache read issue
//   c_waddr_valid/c_waddr/c_wdata   : cache write issue
//   c_rdata, c_stall                : cache read data, cache busy
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = CACHE_RD_LAT,
    parameter int OFFSET_W = CACHE_OFFSET_W,
    parameter int INDEX_W  = CACHE_INDEX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              dm_req_valid,
    input  logic              dm_req_we,
    input  logic [ADDR_W-1:0] dm_req_addr,
    input  logic [DATA_W-1:0] dm_req_wdata,
    output logic              dm_req_ready,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rsp_data,
    output logic              c_raddr_valid,
    output logic [ADDR_W-1:0] c_raddr,
    output logic              c_waddr_valid,
    output logic [ADDR_W-1:0] c_waddr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic [DATA_W-1:0] c_rdata,
    input  logic              c_stall
);

    req_id_e            last_grant_q, last_grant_d;
    logic               lw_valid_q, lw_valid_d;
    logic [INDEX_W-1:0] lw_index_q, lw_index_d;

    logic [INDEX_W-1:0] if_idx, dm_idx;
    logic               if_raw, dm_raw;
    logic               if_elig, dm_elig;
    logic               gnt_if, gnt_dm;
    logic               dm_rd_gnt, dm_wr_gnt;
    inflight_t          issue_tag, rsp_tag;

    // Grant decision and cache issue (all combinational in the grant cycle)
    always_comb begin
        if_idx = if_req_addr[OFFSET_W +: INDEX_W];
        dm_idx = dm_req_addr[OFFSET_W +: INDEX_W];

        // A read to the line written last cycle would race the SRAM write,
        // so it waits one cycle. DM writes are never blocked.
        if_raw = lw_valid_q && (if_idx == lw_index_q);
        dm_raw = lw_valid_q && !dm_req_we && (dm_idx == lw_index_q);

        // rst in the enable makes readies drop the instant reset asserts.
        if_elig = rst && !c_stall && if_req_valid && !if_raw;
        dm_elig = rst && !c_stall && dm_req_valid && !dm_raw;

        gnt_if = if_elig && (!dm_elig || other_req(last_grant_q) == REQ_IF);
        gnt_dm = dm_elig && !gnt_if;

        dm_rd_gnt = gnt_dm && !dm_req_we;
        dm_wr_gnt = gnt_dm && dm_req_we;

        if_req_ready = gnt_if;
        dm_req_ready = gnt_dm;

        c_raddr_valid = gnt_if || dm_rd_gnt;
        c_raddr       = '0;
        if (gnt_if) begin
            c_raddr = if_req_addr;
        end else if (dm_rd_gnt) begin
            c_raddr = dm_req_addr;
        end

        c_waddr_valid = dm_wr_gnt;
        c_waddr       = dm_wr_gnt ? dm_req_addr  : '0;
        c_wdata       = dm_wr_gnt ? dm_req_wdata : '0;

        issue_tag.valid = c_raddr_valid;
        issue_tag.id    = gnt_if ? REQ_IF : REQ_DM;

        last_grant_d = last_grant_q;
        if (gnt_if) begin
            last_grant_d = REQ_IF;
        end else if (gnt_dm) begin
            last_grant_d = REQ_DM;
        end

        lw_valid_d = dm_wr_gnt;
        lw_index_d = dm_wr_gnt ? dm_idx : lw_index_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= REQ_DM;
            lw_valid_q   <= 1'b0;
            lw_index_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lw_valid_q   <= lw_valid_d;
            lw_index_q   <= lw_index_d;
        end
    end

    // Response stage: tags arrive RD_LAT cycles after issue
    rsp_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk_i   (clk),
        .rst_ni  (rst),
        .entry_i (issue_tag),
        .entry_o (rsp_tag)
    );

    always_comb begin
        if_rsp_valid = rsp_tag.valid && (rsp_tag.id == REQ_IF);
        dm_rsp_valid = rsp_tag.valid && (rsp_tag.id == REQ_DM);
        if_rsp_data  = if_rsp_valid ? c_rdata : '0;
        dm_rsp_data  = dm_rsp_valid ? c_rdata : '0;
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
module tb_cache_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        c_raddr_valid;
    logic [31:0] c_raddr;
    logic        c_waddr_valid;
    logic [31:0] c_waddr;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic        c_stall;

    int checks = 0;
    int errors = 0;

    cache_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .dm_req_valid  (dm_req_valid),
        .dm_req_we     (dm_req_we),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_ready  (dm_req_ready),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_data   (dm_rsp_data),
        .c_raddr_valid (c_raddr_valid),
        .c_raddr       (c_raddr),
        .c_waddr_valid (c_waddr_valid),
        .c_waddr       (c_waddr),
        .c_wdata       (c_wdata),
        .c_rdata       (c_rdata),
        .c_stall       (c_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        if_req_valid = 1'b0;
        if_req_addr  = '0;
        dm_req_valid = 1'b0;
        dm_req_we    = 1'b0;
        dm_req_addr  = '0;
        dm_req_wdata = '0;
        c_stall      = 1'b0;
        c_rdata      = '0;
    endtask

    // Advance to just after the next rising edge: start of a new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Returns at the start of cycle 0 with reset released.
    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
    endtask

    // Expected tables
    bit e_b_ifr [7] = '{1, 0, 1, 0, 0, 0, 0};
    bit e_b_dmr [7] = '{0, 1, 0, 1, 0, 0, 0};
    bit e_b_ifv [7] = '{0, 0, 1, 0, 1, 0, 0};
    bit e_b_dmv [7] = '{0, 0, 0, 1, 0, 1, 0};
    logic [31:0] e_b_ra [7] = '{32'h10, 32'h20, 32'h10, 32'h20, 32'h0, 32'h0, 32'h0};

    bit d_stall [6] = '{0, 0, 1, 1, 1, 0};
    bit e_d_ifr [6] = '{1, 0, 0, 0, 0, 1};
    bit e_d_dmr [6] = '{0, 1, 0, 0, 0, 0};
    bit e_d_rv  [6] = '{1, 1, 0, 0, 0, 1};
    bit e_d_ifv [6] = '{0, 0, 1, 0, 0, 0};
    bit e_d_dmv [6] = '{0, 0, 0, 1, 0, 0};

    initial begin
        rst = 1'b0;
        idle();

        // Reset state with both requesters asking
        if_req_valid = 1'b1;
        if_req_addr  = 32'h100;
        dm_req_valid = 1'b1;
        dm_req_addr  = 32'h200;
        sample();
        check("rst if_rdy", {31'b0, if_req_ready}, 32'h0);
        check("rst dm_rdy", {31'b0, dm_req_ready}, 32'h0);
        check("rst rv",     {31'b0, c_raddr_valid}, 32'h0);
        check("rst raddr",  c_raddr, 32'h0);
        check("rst rspv",   {30'b0, if_rsp_valid, dm_rsp_valid}, 32'h0);

        // Single IF read at 0x100
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h100;
        sample();
        check("A0 if_rdy", {31'b0, if_req_ready}, 32'h1);
        check("A0 dm_rdy", {31'b0, dm_req_ready}, 32'h0);
        check("A0 rv",     {31'b0, c_raddr_valid}, 32'h1);
        check("A0 raddr",  c_raddr, 32'h100);
        check("A0 wv",     {31'b0, c_waddr_valid}, 32'h0);
        step();
        idle();
        sample();
        check("A1 ifv", {31'b0, if_rsp_valid}, 32'h0);
        step();
        c_rdata = 32'h1234_5678;
        sample();
        check("A2 ifv",   {31'b0, if_rsp_valid}, 32'h1);
        check("A2 ifd",   if_rsp_data, 32'h1234_5678);
        check("A2 dmv",   {31'b0, dm_rsp_valid}, 32'h0);
        check("A2 dmd",   dm_rsp_data, 32'h0);
        step();
        c_rdata = 32'hFFFF_0000;
        sample();
        check("A3 ifv", {31'b0, if_rsp_valid}, 32'h0);
        check("A3 ifd", if_rsp_data, 32'h0);

        // Both requesters reading continuously: round-robin IF, DM, IF, DM
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            if_req_valid = (i < 4);
            if_req_addr  = 32'h10;
            dm_req_valid = (i < 4);
            dm_req_we    = 1'b0;
            dm_req_addr  = 32'h20;
            c_rdata      = 32'hB000_0000 + i;
            sample();
            check($sformatf("B%0d if_rdy", i), {31'b0, if_req_ready}, {31'b0, e_b_ifr[i]});
            check($sformatf("B%0d dm_rdy", i), {31'b0, dm_req_ready}, {31'b0, e_b_dmr[i]});
            check($sformatf("B%0d raddr", i), c_raddr, e_b_ra[i]);
            check($sformatf("B%0d ifv", i), {31'b0, if_rsp_valid}, {31'b0, e_b_ifv[i]});
            check($sformatf("B%0d dmv", i), {31'b0, dm_rsp_valid}, {31'b0, e_b_dmv[i]});
            check($sformatf("B%0d ifd", i), if_rsp_data, e_b_ifv[i] ? 32'hB000_0000 + i : 32'h0);
            check($sformatf("B%0d dmd", i), dm_rsp_data, e_b_dmv[i] ? 32'hB000_0000 + i : 32'h0);
        end

        // RAW guard: write 0x2040, then IF read 0x2048 (same index 0x04)
        do_reset();
        dm_req_valid = 1'b1;
        dm_req_we    = 1'b1;
        dm_req_addr  = 32'h2040;
        dm_req_wdata = 32'hDEAD_BEEF;
        sample();
        check("C0 dm_rdy", {31'b0, dm_req_ready}, 32'h1);
        check("C0 wv",     {31'b0, c_waddr_valid}, 32'h1);
        check("C0 waddr",  c_waddr, 32'h2040);
        check("C0 wdata",  c_wdata, 32'hDEAD_BEEF);
        check("C0 rv",     {31'b0, c_raddr_valid}, 32'h0);
        step();
        dm_req_we    = 1'b0;
        dm_req_addr  = 32'h3000;
        dm_req_wdata = '0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h2048;
        sample();
        check("C1 if_rdy", {31'b0, if_req_ready}, 32'h0);
        check("C1 dm_rdy", {31'b0, dm_req_ready}, 32'h1);
        check("C1 raddr",  c_raddr, 32'h3000);
        check("C1 wv",     {31'b0, c_waddr_valid}, 32'h0);
        step();
        dm_req_valid = 1'b0;
        sample();
        check("C2 if_rdy", {31'b0, if_req_ready}, 32'h1);
        check("C2 raddr",  c_raddr, 32'h2048);
        check("C2 dmv",    {31'b0, dm_rsp_valid}, 32'h0);
        step();
        if_req_valid = 1'b0;
        c_rdata = 32'hC3C3_0003;
        sample();
        check("C3 dmv", {31'b0, dm_rsp_valid}, 32'h1);
        check("C3 dmd", dm_rsp_data, 32'hC3C3_0003);
        check("C3 ifv", {31'b0, if_rsp_valid}, 32'h0);
        step();
        c_rdata = 32'hC4C4_0004;
        sample();
        check("C4 ifv", {31'b0, if_rsp_valid}, 32'h1);
        check("C4 ifd", if_rsp_data, 32'hC4C4_0004);
        check("C4 dmv", {31'b0, dm_rsp_valid}, 32'h0);

        // Stall in cycles 3-5 with both requesters pending from cycle 1
        do_reset();
        sample();
        check("D0 rv", {31'b0, c_raddr_valid}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            if_req_valid = 1'b1;
            if_req_addr  = 32'h40;
            dm_req_valid = 1'b1;
            dm_req_we    = 1'b0;
            dm_req_addr  = 32'h80;
            c_stall      = d_stall[i];
            c_rdata      = 32'hD000_0001 + i;
            sample();
            check($sformatf("D%0d if_rdy", i + 1), {31'b0, if_req_ready}, {31'b0, e_d_ifr[i]});
            check($sformatf("D%0d dm_rdy", i + 1), {31'b0, dm_req_ready}, {31'b0, e_d_dmr[i]});
            check($sformatf("D%0d rv", i + 1), {31'b0, c_raddr_valid}, {31'b0, e_d_rv[i]});
            check($sformatf("D%0d ifv", i + 1), {31'b0, if_rsp_valid}, {31'b0, e_d_ifv[i]});
            check($sformatf("D%0d dmv", i + 1), {31'b0, dm_rsp_valid}, {31'b0, e_d_dmv[i]});
            check($sformatf("D%0d ifd", i + 1), if_rsp_data, e_d_ifv[i] ? 32'hD000_0001 + i : 32'h0);
            check($sformatf("D%0d dmd", i + 1), dm_rsp_data, e_d_dmv[i] ? 32'hD000_0001 + i : 32'h0);
        end

        // Reset asserted one cycle after a read grant drops the read
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h500;
        sample();
        check("E0 if_rdy", {31'b0, if_req_ready}, 32'h1);
        step();
        rst = 1'b0;
        c_rdata = 32'hEEEE_0001;
        sample();
        check("E1 rdys",  {30'b0, if_req_ready, dm_req_ready}, 32'h0);
        check("E1 rv",    {30'b0, c_raddr_valid, c_waddr_valid}, 32'h0);
        check("E1 raddr", c_raddr, 32'h0);
        check("E1 rspv",  {30'b0, if_rsp_valid, dm_rsp_valid}, 32'h0);
        step();
        c_rdata = 32'hEEEE_0002;
        sample();
        check("E2 rspv", {30'b0, if_rsp_valid, dm_rsp_valid}, 32'h0);
        check("E2 ifd",  if_rsp_data, 32'h0);
        step();
        rst = 1'b1;
        idle();
        c_rdata = 32'hEEEE_0003;
        sample();
        check("E3 rspv", {30'b0, if_rsp_valid, dm_rsp_valid}, 32'h0);
        step();
        sample();
        check("E4 rspv", {30'b0, if_rsp_valid, dm_rsp_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
